// File: rtl/aurora_hls_crc_stats.sv
// aurora_hls_crc_stats: per-channel CRC frame/error counters, burst flag, snapshot and read-and-clear
// Optional feature macro: AURORA_HLS_CRC_FIRST_ERR_EN (first failing frame index per channel)
module aurora_hls_crc_stats #(
  parameter int NUM_CHANNELS    = 4,
  parameter int CNT_WIDTH       = 32,
  parameter int SATURATE        = 1,
  parameter int RUN_WIDTH       = 16,
  parameter int BURST_THRESHOLD = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CHANNELS-1:0]           crc_valid,
  input  logic [NUM_CHANNELS-1:0]           crc_pass_fail_n,
  input  logic                              clear,
  input  logic                              snapshot_req,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] frames_received,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] frames_with_errors,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] snap_frames_received,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] snap_frames_with_errors,
  output logic                              snapshot_done,
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] first_err_index,
  output logic [NUM_CHANNELS-1:0]           first_err_valid,
`endif
  output logic [NUM_CHANNELS-1:0]           burst_flag
);
  localparam int W = NUM_CHANNELS * CNT_WIDTH;
  localparam int R = NUM_CHANNELS * RUN_WIDTH;
  logic [W-1:0] fr_q, fr_d, fe_q, fe_d, sfr_q, sfr_d, sfe_q, sfe_d;
  logic [R-1:0] run_q, run_d;
  logic [NUM_CHANNELS-1:0] burst_q, burst_d;
  logic done_q, done_d;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
  logic [W-1:0] fi_q, fi_d;
  logic [NUM_CHANNELS-1:0] fv_q, fv_d;
`endif

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
    return (SATURATE != 0 && &v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [RUN_WIDTH-1:0] bump_run(input logic [RUN_WIDTH-1:0] v);
    return (&v) ? v : v + RUN_WIDTH'(1);
  endfunction

  // Next-state: snapshot copies pre-edge live values; clear wins over same-cycle events
  always_comb begin
    fr_d    = fr_q;
    fe_d    = fe_q;
    run_d   = run_q;
    burst_d = burst_q;
    done_d  = snapshot_req;
    sfr_d   = snapshot_req ? fr_q : sfr_q;
    sfe_d   = snapshot_req ? fe_q : sfe_q;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
    fi_d    = fi_q;
    fv_d    = fv_q;
`endif
    if (clear) begin
      fr_d    = '0;
      fe_d    = '0;
      run_d   = '0;
      burst_d = '0;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
      fi_d    = '0;
      fv_d    = '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (crc_valid[i]) begin
          fr_d[i*CNT_WIDTH +: CNT_WIDTH] = bump(fr_q[i*CNT_WIDTH +: CNT_WIDTH]);
          fe_d[i*CNT_WIDTH +: CNT_WIDTH] = crc_pass_fail_n[i] ? fe_q[i*CNT_WIDTH +: CNT_WIDTH]
                                                              : bump(fe_q[i*CNT_WIDTH +: CNT_WIDTH]);
          run_d[i*RUN_WIDTH +: RUN_WIDTH] = crc_pass_fail_n[i] ? '0 : bump_run(run_q[i*RUN_WIDTH +: RUN_WIDTH]);
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
          if (!crc_pass_fail_n[i] && !fv_q[i]) begin
            fi_d[i*CNT_WIDTH +: CNT_WIDTH] = fr_q[i*CNT_WIDTH +: CNT_WIDTH];
            fv_d[i] = 1'b1;
          end
`endif
        end
        burst_d[i] = burst_q[i] | (run_d[i*RUN_WIDTH +: RUN_WIDTH] == RUN_WIDTH'(BURST_THRESHOLD));
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fr_q    <= '0;
      fe_q    <= '0;
      sfr_q   <= '0;
      sfe_q   <= '0;
      run_q   <= '0;
      burst_q <= '0;
      done_q  <= 1'b0;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
      fi_q    <= '0;
      fv_q    <= '0;
`endif
    end else begin
      fr_q    <= fr_d;
      fe_q    <= fe_d;
      sfr_q   <= sfr_d;
      sfe_q   <= sfe_d;
      run_q   <= run_d;
      burst_q <= burst_d;
      done_q  <= done_d;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
      fi_q    <= fi_d;
      fv_q    <= fv_d;
`endif
    end
  end

  assign frames_received         = fr_q;
  assign frames_with_errors      = fe_q;
  assign snap_frames_received    = sfr_q;
  assign snap_frames_with_errors = sfe_q;
  assign snapshot_done           = done_q;
  assign burst_flag              = burst_q;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
  assign first_err_index         = fi_q;
  assign first_err_valid         = fv_q;
`endif
endmodule

// File: tb/tb_aurora_hls_crc_stats.sv
// tb_aurora_hls_crc_stats: directed checks of counters, burst, snapshot, clear, saturation/wrap and reset
module tb_aurora_hls_crc_stats;
  logic clk = 1'b0;
  logic rst_n, clear, snapshot_req;
  logic [3:0] crc_valid, crc_pass_fail_n;
  logic [31:0] fr, fe, sfr, sfe, wfr, wfe, wsfr, wsfe;
  logic done, wdone;
  logic [3:0] burst, wburst;
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
  logic [31:0] fidx, wfidx;
  logic [3:0] fval, wfval;
`endif
  int total = 0;
  int bad = 0;
  bit seq [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  aurora_hls_crc_stats #(.NUM_CHANNELS(4), .CNT_WIDTH(8), .SATURATE(1), .RUN_WIDTH(16), .BURST_THRESHOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .crc_valid(crc_valid), .crc_pass_fail_n(crc_pass_fail_n),
    .clear(clear), .snapshot_req(snapshot_req),
    .frames_received(fr), .frames_with_errors(fe),
    .snap_frames_received(sfr), .snap_frames_with_errors(sfe),
    .snapshot_done(done),
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
    .first_err_index(fidx), .first_err_valid(fval),
`endif
    .burst_flag(burst));

  aurora_hls_crc_stats #(.NUM_CHANNELS(4), .CNT_WIDTH(8), .SATURATE(0), .RUN_WIDTH(16), .BURST_THRESHOLD(4)) dutw (
    .clk(clk), .rst_n(rst_n), .crc_valid(crc_valid), .crc_pass_fail_n(crc_pass_fail_n),
    .clear(clear), .snapshot_req(snapshot_req),
    .frames_received(wfr), .frames_with_errors(wfe),
    .snap_frames_received(wsfr), .snap_frames_with_errors(wsfe),
    .snapshot_done(wdone),
`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
    .first_err_index(wfidx), .first_err_valid(wfval),
`endif
    .burst_flag(wburst));

  function automatic logic [7:0] ch(input logic [31:0] bus, input int c);
    return bus[c*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    crc_valid = 4'b0;
    crc_pass_fail_n = 4'b0;
    clear = 1'b0;
    snapshot_req = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_fr", fr, 0);
    chk("rst_fe", fe, 0);
    chk("rst_sfr", sfr, 0);
    chk("rst_sfe", sfe, 0);
    chk("rst_done", done, 0);
    chk("rst_burst", burst, 0);

    crc_valid = 4'b0001;
    crc_pass_fail_n = 4'b0001;
    tick();
    chk("latency_fr0", ch(fr, 0), 1);
    for (int i = 0; i < 9; i++) tick();
    idle();
    tick();
    chk("pass10_fr0", ch(fr, 0), 10);
    chk("pass10_fe0", ch(fe, 0), 0);
    chk("pass10_burst", burst, 0);
    chk("pass10_others", fr[31:8], 0);

    for (int i = 0; i < 7; i++) begin
      crc_valid = 4'b0010;
      crc_pass_fail_n = {2'b0, seq[i], 1'b0};
      tick();
      if (i == 5) chk("run3_burst1", burst[1], 0);
      if (i == 6) chk("run4_burst1", burst[1], 1);
    end
    idle();
    chk("seq_fr1", ch(fr, 1), 7);
    chk("seq_fe1", ch(fe, 1), 6);
    crc_valid = 4'b0010;
    crc_pass_fail_n = 4'b0010;
    tick();
    idle();
    chk("sticky_burst1", burst[1], 1);
    chk("sticky_fr1", ch(fr, 1), 8);
    chk("sticky_burst_others", {burst[3:2], burst[0]}, 0);

    crc_valid = 4'b0100;
    crc_pass_fail_n = 4'b0100;
    for (int i = 0; i < 260; i++) tick();
    idle();
    chk("sat_fr2", ch(fr, 2), 255);
    chk("wrap_fr2", ch(wfr, 2), 4);
    chk("wrap_fr0", ch(wfr, 0), 10);

    clear = 1'b1;
    tick();
    idle();
    chk("clear_fr", fr, 0);
    chk("clear_burst", burst, 0);
    crc_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      crc_pass_fail_n = (i < 2) ? 4'b0000 : 4'b0001;
      tick();
    end
    idle();
    chk("pre_rc_fr0", ch(fr, 0), 5);
    chk("pre_rc_fe0", ch(fe, 0), 2);
    chk("pre_rc_done", done, 0);
    snapshot_req = 1'b1;
    clear = 1'b1;
    crc_valid = 4'b0001;
    crc_pass_fail_n = 4'b0000;
    tick();
    idle();
    chk("rc_snap_fr0", ch(sfr, 0), 5);
    chk("rc_snap_fe0", ch(sfe, 0), 2);
    chk("rc_live_fr0", ch(fr, 0), 0);
    chk("rc_live_fe0", ch(fe, 0), 0);
    chk("rc_done", done, 1);
    tick();
    chk("rc_done_low", done, 0);
    clear = 1'b1;
    tick();
    idle();
    chk("clear_keeps_snap", ch(sfr, 0), 5);

    snapshot_req = 1'b1;
    crc_valid = 4'b0001;
    crc_pass_fail_n = 4'b0001;
    tick();
    crc_valid = 4'b0000;
    chk("b2b_a_snap", ch(sfr, 0), 0);
    chk("b2b_a_live", ch(fr, 0), 1);
    chk("b2b_a_done", done, 1);
    tick();
    idle();
    chk("b2b_b_snap", ch(sfr, 0), 1);
    chk("b2b_b_done", done, 1);
    tick();
    chk("b2b_done_low", done, 0);

    clear = 1'b1;
    tick();
    idle();
    crc_valid = 4'b1111;
    crc_pass_fail_n = 4'b0111;
    for (int i = 0; i < 100; i++) tick();
    idle();
    chk("all_fr", fr, 32'h64646464);
    chk("all_fe", fe, 32'h64000000);
    chk("all_burst", burst, 4'b1000);

    snapshot_req = 1'b1;
    crc_valid = 4'b1111;
    tick();
    rst_n = 1'b0;
    snapshot_req = 1'b0;
    tick();
    chk("midrst_fr", fr, 0);
    chk("midrst_fe", fe, 0);
    chk("midrst_sfr", sfr, 0);
    chk("midrst_sfe", sfe, 0);
    chk("midrst_done", done, 0);
    chk("midrst_burst", burst, 0);
    rst_n = 1'b1;
    idle();
    tick();
    chk("postrst_done", done, 0);
    chk("postrst_fr", fr, 0);

`ifdef AURORA_HLS_CRC_FIRST_ERR_EN
    chk("fe_rst_valid", fval, 0);
    crc_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      crc_pass_fail_n = (i < 3) ? 4'b0001 : 4'b0000;
      tick();
    end
    idle();
    chk("first_idx0", ch(fidx, 0), 3);
    chk("first_val", fval, 4'b0001);
    chk("first_idx_wrap", ch(wfidx, 0), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
